dmem_write_buffer: RTL
======================

DMEM_WRITE_BUFFER -- requirements
Module: dmem_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered line writebacks (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port proc_read  input  1  cache-side line read request, held until proc_ready.
REQ-005 SHALL have port proc_write  input  1  cache-side line write request, held until proc_ready.
REQ-006 SHALL have port proc_addr  input  28  line address [31:4].
REQ-007 SHALL have port proc_wdata  input  128  write line data.
REQ-008 SHALL have port proc_rdata  output  128  read line data, valid while proc_ready=1.
REQ-009 SHALL have port proc_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports mem_read/mem_write output 1, mem_addr output 28, mem_wdata output 128, mem_rdata input 128, mem_ready input 1: slow-memory side, same hold-until-ready protocol.

Function
REQ-011 SHALL hold buffered writes in a circular FIFO (head, tail, count 0..DEPTH); full = count==DEPTH, empty = count==0.
REQ-012 SHALL accept proc_write when not full: enqueue (or coalesce, REQ-013) and pulse proc_ready the following cycle; when full, stall with proc_ready=0 until a drain pop frees an entry.
REQ-013 SHALL coalesce a write whose address matches a valid entry other than the one in flight to memory: overwrite that entry's data in place, count unchanged, proc_ready next cycle.
REQ-014 SHALL run a drain FSM with states IDLE, WR, RD, RESP.
REQ-015 IDLE->RD when an eligible read is pending (read has priority); IDLE->WR when not empty and no eligible read; else stay IDLE.
REQ-016 WR: mem_write=1 with head address/data held stable; on mem_ready pop head (count-1) and return to IDLE.
REQ-017 RD: mem_read=1 with proc_addr; on mem_ready register mem_rdata into proc_rdata and go to RESP.
REQ-018 RESP: proc_ready=1 for exactly one cycle, then IDLE.
REQ-019 mem_read and mem_write SHALL never be high together; all outputs SHALL be registered.
REQ-020 Simultaneous pop and enqueue in one cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-021 proc_read and proc_write both high is illegal; write SHALL take precedence.

Reset
REQ-022 On rst_n low, asynchronously: proc_ready, mem_read, mem_write = 0; proc_rdata, mem_addr, mem_wdata = 0; count, head, tail = 0; FSM = IDLE; all entry valid bits cleared.
REQ-023 Reset mid-transaction SHALL abandon the in-flight access and discard all buffered writes; no output pulses after release until a new request arrives.

Configuration
REQ-024 Macro WBUF_FWD_EN defined: a read matching a buffered entry SHALL return that entry's data (youngest on duplicates) with proc_ready the next cycle and no memory access; a non-matching read is eligible immediately (bypasses buffered writes).
REQ-025 WBUF_FWD_EN undefined: a read SHALL become eligible only when the buffer is empty; no forwarding logic exists.

Structure
REQ-026 Package wbuf_pkg SHALL hold ADDR_W=28, LINE_W=128, the FSM state enum and the entry struct {valid, addr, data}.
REQ-027 Sub-module wbuf_match SHALL hold the combinational address compare over all entries, returning hit, hit index and youngest-hit index.

Verification
REQ-028 Write 0x0000010 data A, memory ready after 10 cycles -> proc_ready at cycle 1; mem_write with addr 0x0000010 / A until mem_ready; count returns to 0.
REQ-029 Five writes to distinct addresses, DEPTH=4, memory stalled -> first four ack in consecutive-plus-one cycles, fifth stalls until first mem_ready, then acks.
REQ-030 Write 0x20 data A, then 0x20 data B while head 0x10 in flight -> count stays 2; memory later receives 0x20 with B only once.
REQ-031 FWD_EN: write 0x30 data C, then read 0x30 -> proc_rdata=C, proc_ready next cycle, mem_read never asserted; FWD off: read waits until empty, then mem_read.
REQ-032 Assert rst_n low during WR with count=3 -> outputs zero immediately; after release, read 0x40 goes straight to mem_read.

Source files
------------

// File: rtl/wbuf_pkg.sv
// Shared types for the data-memory write buffer: line geometry, drain FSM states, entry layout.
package wbuf_pkg;
  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/wbuf_match.sv
// Address compare across all buffer entries. The youngest-hit search (oldest-to-youngest
// walk from head) exists only when WBUF_FWD_EN is defined.
module wbuf_match
  import wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  valid,
  input  logic [ADDR_W-1:0] addr [DEPTH],
  input  logic [ADDR_W-1:0] key,
  input  logic              excl_en,
  input  logic [IDX_W-1:0]  excl_idx,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx
`ifdef WBUF_FWD_EN
  ,
  input  logic [IDX_W-1:0]  head,
  output logic              young_hit,
  output logic [IDX_W-1:0]  young_idx
`endif
);
  logic [DEPTH-1:0] match;

  // Raw per-entry address match
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (addr[i] == key);
    end
  end

  // Coalesce target: the entry in flight to memory must never be rewritten
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_idx = (match[i] && !(excl_en && (excl_idx == IDX_W'(i)))) ? IDX_W'(i) : hit_idx;
      hit     = hit | (match[i] && !(excl_en && (excl_idx == IDX_W'(i))));
    end
  end

`ifdef WBUF_FWD_EN
  logic [IDX_W-1:0] pos;

  // Walk from head towards tail so the last match seen is the youngest
  always_comb begin
    young_hit = 1'b0;
    young_idx = '0;
    pos       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos       = head + IDX_W'(k);
      young_idx = match[pos] ? pos : young_idx;
      young_hit = young_hit | match[pos];
    end
  end
`endif
endmodule

// File: rtl/dmem_write_buffer.sv
// Line write buffer between the data cache and slow memory, drained by a small FSM.
// Define WBUF_FWD_EN to forward buffered lines to reads and let misses bypass the buffer.
module dmem_write_buffer
  import wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [LINE_W-1:0] proc_wdata,
  output logic [LINE_W-1:0] proc_rdata,
  output logic              proc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t            ent [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [IDX_W-1:0]  head, tail, hit_idx;
  logic [CNT_W-1:0]  count;
  state_t            state, state_nxt;
  logic full, empty, wr_req, rd_req, rd_elig, hit, coalesce, enq, pop, rd_done;
  logic go_wr, go_rd, excl_en, ack;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign ent_valid[g] = ent[g].valid;
    assign ent_addr[g]  = ent[g].addr;
  end

  // A request still high during its own proc_ready cycle is already served
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign wr_req   = proc_write && !proc_ready;
  assign rd_req   = proc_read && !proc_write && !proc_ready;
  assign coalesce = wr_req && hit;
  assign enq      = wr_req && !hit && !full;
  assign pop      = (state == ST_WR) && mem_ready;
  assign rd_done  = (state == ST_RD) && mem_ready;
  assign go_wr    = (state == ST_IDLE) && (state_nxt == ST_WR);
  assign go_rd    = (state == ST_IDLE) && (state_nxt == ST_RD);
  assign excl_en  = (state == ST_WR) || go_wr;

`ifdef WBUF_FWD_EN
  logic             young_hit, fwd;
  logic [IDX_W-1:0] young_idx;

  assign fwd     = rd_req && young_hit;
  assign rd_elig = rd_req && !young_hit;
  assign ack     = coalesce || enq || fwd || rd_done;

  wbuf_match #(.DEPTH(DEPTH)) u_match (
    .valid(ent_valid), .addr(ent_addr), .key(proc_addr), .excl_en(excl_en), .excl_idx(head),
    .hit(hit), .hit_idx(hit_idx), .head(head), .young_hit(young_hit), .young_idx(young_idx)
  );
`else
  assign rd_elig = rd_req && empty;
  assign ack     = coalesce || enq || rd_done;

  wbuf_match #(.DEPTH(DEPTH)) u_match (
    .valid(ent_valid), .addr(ent_addr), .key(proc_addr), .excl_en(excl_en), .excl_idx(head),
    .hit(hit), .hit_idx(hit_idx)
  );
`endif

  // Drain FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Drain FSM next state: reads win over draining
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rd_elig)     state_nxt = ST_RD;
        else if (!empty) state_nxt = ST_WR;
        else             state_nxt = ST_IDLE;
      end
      ST_WR:   state_nxt = mem_ready ? ST_IDLE : ST_WR;
      ST_RD:   state_nxt = mem_ready ? ST_RESP : ST_RD;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Circular FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        ent[head].valid <= 1'b0;
        head            <= head + IDX_W'(1);
      end
      if (enq) begin
        ent[tail] <= '{valid: 1'b1, addr: proc_addr, data: proc_wdata};
        tail      <= tail + IDX_W'(1);
      end else if (coalesce) begin
        ent[hit_idx].data <= proc_wdata;
      end
      case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered processor- and memory-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_ready <= 1'b0;
      proc_rdata <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      proc_ready <= ack;
      if (rd_done) proc_rdata <= mem_rdata;
`ifdef WBUF_FWD_EN
      else if (fwd) proc_rdata <= ent[young_idx].data;
`endif
      if (go_wr) begin
        mem_write <= 1'b1;
        mem_addr  <= ent[head].addr;
        mem_wdata <= ent[head].data;
      end else if (pop) begin
        mem_write <= 1'b0;
      end
      if (go_rd) begin
        mem_read <= 1'b1;
        mem_addr <= proc_addr;
      end else if (rd_done) begin
        mem_read <= 1'b0;
      end
    end
  end
endmodule
